// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  localparam int unsigned PARITY_NONE   = 0;
  localparam int unsigned PARITY_ODD    = 1;
  localparam int unsigned PARITY_EVEN   = 2;

  // Widest data field the receiver can be configured for.
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_PUSH
  } rx_state_e;

  // One received frame as stored in the output FIFO.
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     parity_err;
    logic                     frame_err;
  } rx_entry_t;

  localparam int unsigned ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_rx_fifo.sv
// Power-of-two FIFO with a registered head-of-queue output.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Pops only from a non-empty FIFO; a push into a full FIFO succeeds only alongside a pop.
  always_comb begin
    pop_ok   = pop & ~empty_q;
    push_ok  = push & (~full_q | pop_ok);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    head_d   = mem_d[rd_ptr_d];
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Storage, pointers and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head_data = head_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, 3-sample majority decoder and output FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          data_received,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          valid,
  input  logic                          ready,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned HALF    = CLKS_PER_BIT / 2;
  localparam int unsigned SMP0    = HALF - 1;
  localparam int unsigned SMP1    = HALF;
  localparam int unsigned VOTE    = HALF + 1;
  localparam int unsigned LAST    = CLKS_PER_BIT - 1;

  if (CLKS_PER_BIT < 8) begin : g_bad_clks
    $error("CLKS_PER_BIT must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [1:0]           sync_q, sync_d;
  logic [1:0]           settle_q, settle_d;
  logic                 rx_prev_q, rx_prev_d;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic                 rx_s, vote_c, at_vote_c, at_end_c, push_c, pop_c;
  logic                 fifo_full, fifo_empty;
  rx_entry_t            push_entry, head_entry;

  // Synchroniser; rx_prev only tracks the line once real samples have reached stage two,
  // so a line already low at reset release never looks like a falling edge.
  always_comb begin
    sync_d    = {sync_q[0], rx};
    settle_d  = {settle_q[0], 1'b1};
    rx_s      = sync_q[1];
    rx_prev_d = settle_q[1] & rx_s;
  end

  // Majority of the two stored samples and the live third sample.
  always_comb begin
    vote_c    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    at_vote_c = (cnt_q == CNT_W'(VOTE));
    at_end_c  = (cnt_q == CNT_W'(LAST));
  end

  // Frame decoder next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push_c  = 1'b0;

    if (state_q != ST_IDLE && state_q != ST_PUSH) begin
      cnt_d = at_end_c ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(SMP0)) smp_d[0] = rx_s;
      if (cnt_q == CNT_W'(SMP1)) smp_d[1] = rx_s;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (rx_prev_q && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (at_vote_c && vote_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (at_end_c) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_vote_c) shreg_d = {vote_c, shreg_q[DATA_BITS-1:1]};
        if (at_end_c) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (at_vote_c) perr_d = (((^shreg_q) ^ vote_c) != (PARITY == PARITY_ODD));
        if (at_end_c) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (at_vote_c) begin
          if (!vote_c) ferr_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = ST_PUSH;
            cnt_d   = '0;
          end
        end else if (at_end_c) begin
          stop_d = 1'b1;
        end
      end
      ST_PUSH: begin
        push_c  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO write payload, pop qualification and dropped-frame detection.
  always_comb begin
    push_entry.data       = MAX_DATA_BITS'(shreg_q);
    push_entry.parity_err = (PARITY != PARITY_NONE) && perr_q;
    push_entry.frame_err  = ferr_q;
    pop_c                 = ready & ~fifo_empty;
    overrun_d             = push_c & fifo_full & ~pop_c;
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      settle_q  <= 2'b00;
      rx_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      smp_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      settle_q  <= settle_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      smp_q     <= smp_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (ready),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  if (DATA_BITS < MAX_DATA_BITS) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^head_entry.data[MAX_DATA_BITS-1:DATA_BITS];
  end

  assign data_received = head_entry.data[DATA_BITS-1:0];
  assign parity_err    = head_entry.parity_err;
  assign frame_err     = head_entry.frame_err;
  assign valid         = ~fifo_empty;
  assign overrun       = overrun_q;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per bit; SHALL be >= 8.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; SHALL be 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame; SHALL be 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, output FIFO entries; SHALL be a power of 2 and >= 2.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-009 data_received  output  DATA_BITS  head-of-FIFO data, LSB first on the line.
REQ-010 parity_err  output  1  head-of-FIFO parity mismatch flag; held 0 when PARITY=0.
REQ-011 frame_err  output  1  head-of-FIFO flag: any stop bit sampled low.
REQ-012 valid  output  1  FIFO non-empty.
REQ-013 ready  input  1  consumer accepts head entry.
REQ-014 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 rx SHALL pass through a 2-FF synchroniser; only the second-stage output SHALL drive decoding.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and PUSH.
REQ-018 IDLE -> START SHALL occur on a synchronised high-to-low transition only.
REQ-019 Each bit value SHALL be the majority of 3 samples at bit-relative counts CLKS_PER_BIT/2-1, /2 and /2+1.
REQ-020 START: voted value 1 is a false start -> IDLE with no push. Voted value 0 -> DATA at the bit boundary.
REQ-021 DATA SHALL shift in DATA_BITS bits LSB first, then go to PARITY if PARITY!=0, otherwise to STOP.
REQ-022 PARITY: parity_err = (XOR of data and parity bit) != (PARITY==1).
REQ-023 STOP: each of STOP_BITS bits is voted; any 0 sets frame_err. After the final stop vote the FSM SHALL go to PUSH without waiting for the bit end.
REQ-024 PUSH SHALL last exactly one cycle and write {data, parity_err, frame_err} to the FIFO, then go to IDLE. The frame is pushed even when errors are flagged.
REQ-025 Back-to-back frames with zero idle time SHALL be received without loss.
REQ-026 Handshake: an entry is popped on any cycle with valid & ready. Outputs SHALL show the new head on the next cycle.
REQ-027 data_received, parity_err and frame_err SHALL be stable while valid=1 and ready=0.
REQ-028 valid SHALL rise the cycle after PUSH into an empty FIFO.
REQ-029 Full FIFO at PUSH with no pop that cycle: the frame is dropped, FIFO is unchanged, overrun pulses 1 cycle.
REQ-030 Full FIFO at PUSH with a simultaneous pop: both SHALL occur, fifo_count is unchanged, no overrun.
REQ-031 Empty FIFO: ready is ignored and pointers do not move.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH. Counters SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-033 While rst=0: FSM SHALL be in IDLE, counters, pointers and fifo_count SHALL be 0, and all outputs SHALL be 0; synchroniser flops SHALL be 1.
REQ-034 Reset asserted mid-frame SHALL abort the frame and discard the FIFO contents.
REQ-035 After rst rises, a frame already in progress SHALL NOT be decoded unless a fresh falling edge is seen.

Structure
REQ-036 Package uart_pkg SHALL hold the parity-mode constants, the FSM state enum and the FIFO entry struct typedef.
REQ-037 The FIFO SHALL be a separate sub-module uart_rx_fifo with parameters WIDTH and DEPTH and a push/pop/full/empty/count interface.
REQ-038 Illegal parameter values SHALL fail elaboration.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-039 8N1, ready=1, send 0xA5 -> exactly one valid pulse with data=0xA5, parity_err=0, frame_err=0.
REQ-040 8E1, send 0x07 with parity bit 0 -> parity_err=1. With parity bit 1 -> parity_err=0.
REQ-041 8N2, send 0x3C with 2nd stop bit low -> data=0x3C, frame_err=1. Then a 0x00 break -> frame_err=1.
REQ-042 rx low for 5 cycles then high -> no push, FSM back in IDLE. A single-cycle glitch inside a data bit -> voted out, data correct.
REQ-043 FIFO_DEPTH=4, ready=0, send 5 frames 0x01..0x05 -> fifo_count=4, one overrun pulse; draining then yields 0x01..0x04. A pop coincident with PUSH on a full FIFO -> no overrun.
REQ-044 rst asserted mid-frame (bit 3), released, then 0x5A sent -> only 0x5A is delivered.
